// File: rtl/pdu_imem_fetch_pkg.sv
// Shared definitions for the PDU instruction-memory fetch engine.
package pdu_imem_fetch_pkg;

  localparam int PDU_FETCH_FIFO_DEPTH = 2;
  localparam int PDU_WORD_W           = 32;

  typedef enum logic {
    PDU_FETCH_IDLE = 1'b0,
    PDU_FETCH_RUN  = 1'b1
  } pdu_fetch_state_e;

endpackage

// File: rtl/pdu_fetch_fifo.sv
// Two-entry synchronous skid FIFO holding {command word, word address}.
// Flush takes precedence over push and pop in the same cycle.
module pdu_fetch_fifo
  import pdu_imem_fetch_pkg::*;
#(
  parameter int unsigned W = 44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The upstream credit rule must never let a word land in a full FIFO.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count_q == 2'(PDU_FETCH_FIFO_DEPTH))));

endmodule

// File: rtl/pdu_imem_fetch.sv
// Sequential IMEM fetch engine: drives the read address, absorbs the one-cycle
// read latency and streams {word, address} through a 2-entry skid FIFO.
module pdu_imem_fetch
  import pdu_imem_fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 12,
  parameter logic [DEPTH-1:0] RESET_PC = '0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [DEPTH-1:0]      redirect_addr,
  output logic [DEPTH-1:0]      imem_addr,
  input  logic [PDU_WORD_W-1:0] imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [PDU_WORD_W-1:0] inst_data,
  output logic [DEPTH-1:0]      inst_addr,
  output logic                  busy
);

  localparam int unsigned ENTRY_W = PDU_WORD_W + DEPTH;

  pdu_fetch_state_e   state_q, state_d;
  logic [DEPTH-1:0]   pc_q, pc_d;
  logic [DEPTH-1:0]   pend_addr_q, pend_addr_d;
  logic               pend_q, pend_d;
  logic               issue;
  logic               pop;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [2:0]         credit_sum;

  assign imem_addr  = pc_q;
  assign inst_valid = (fifo_count != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = fifo_head[ENTRY_W-1:DEPTH];
  assign inst_addr  = fifo_head[DEPTH-1:0];
  assign busy       = (state_q == PDU_FETCH_RUN) | pend_q | inst_valid;

  // Words buffered plus in flight, minus the one leaving this cycle.
  assign credit_sum = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= PDU_FETCH_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: redirect keeps the state unless halt rides along with it.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (halt) state_d = PDU_FETCH_IDLE;
    end else if (halt) begin
      state_d = PDU_FETCH_IDLE;
    end else if (start) begin
      state_d = PDU_FETCH_RUN;
    end
  end

  // FSM output: issue only while running, never on a redirect, within credit.
  always_comb begin
    issue = (state_q == PDU_FETCH_RUN) && !redirect_valid &&
            (credit_sum < 3'(PDU_FETCH_FIFO_DEPTH));
  end

  // pc and in-flight tracking; a redirect discards the word currently landing.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (issue) begin
      pend_d      = 1'b1;
      pend_addr_d = pc_q;
      pc_d        = pc_q + DEPTH'(1);
    end
  end

  // pc / pend registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  pdu_fetch_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (pend_q),
    .push_data ({imem_data, pend_addr_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_pdu_imem_fetch.sv
// Self-checking bench for pdu_imem_fetch: directed timing scenarios followed by
// randomized traffic, all checked against an address-sequence scoreboard.
module tb_pdu_imem_fetch;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_addr = '0;
  logic [11:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [11:0] inst_addr;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int npops = 0;

  logic [11:0] exp_addr = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [11:0] prev_addr = '0;
  logic [11:0] got_q[$];

  always #5 clk = ~clk;

  pdu_imem_fetch #(
    .DEPTH    (12),
    .RESET_PC (12'h000)
  ) dut (
    .sys_clk        (clk),
    .sys_rst        (sys_rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_addr      (inst_addr),
    .busy           (busy)
  );

  function automatic logic [31:0] word_of(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  // IMEM model with one-cycle registered read.
  always @(posedge clk) imem_data <= word_of(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: scoreboard at negedge, then advance past the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (prev_hold) begin
      chk("hold_valid", 64'(inst_valid), 64'(1'b1));
      chk("hold_data", 64'(inst_data), 64'(prev_data));
      chk("hold_addr", 64'(inst_addr), 64'(prev_addr));
    end
    if (inst_valid && inst_ready && !sys_rst) begin
      chk("seq_addr", 64'(inst_addr), 64'(exp_addr));
      chk("seq_data", 64'(inst_data), 64'(word_of(exp_addr)));
      got_q.push_back(inst_addr);
      exp_addr = exp_addr + 12'd1;
      npops++;
    end
    prev_hold = inst_valid && !inst_ready && !redirect_valid && !sys_rst;
    prev_data = inst_data;
    prev_addr = inst_addr;
    if (sys_rst) exp_addr = 12'h000;
    else if (redirect_valid) exp_addr = redirect_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(12'h000));
    chk({tag, "_valid"}, 64'(inst_valid), 64'(1'b0));
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_data"}, 64'(inst_data), 64'(32'h0));
    chk({tag, "_addr"}, 64'(inst_addr), 64'(12'h000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int          n;
    int          sz;

    // Reset
    @(posedge clk); #1;
    cyc();
    sys_rst = 1'b0;
    chk_reset("reset");

    // Start latency and full-rate streaming
    got_q.delete();
    inst_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) start = 1'b0;
      chk("first_valid", 64'(inst_valid), 64'(c >= 3));
      if (c == 1) chk("busy_run", 64'(busy), 64'(1'b1));
      cyc();
    end
    chk("stream_count", 64'(got_q.size()), 64'd9);

    // Backpressure: alternate, then hold low
    for (int c = 0; c < 20; c++) begin
      inst_ready = (c % 2) == 0;
      cyc();
    end
    inst_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) a = imem_addr;
      if (c == 9) chk("bp_no_issue", 64'(imem_addr), 64'(a));
      cyc();
    end
    chk("bp_busy", 64'(busy), 64'(1'b1));
    chk("bp_valid", 64'(inst_valid), 64'(1'b1));
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) cyc();

    // Redirect with a full FIFO
    inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    redirect_valid = 1'b1;
    redirect_addr  = 12'h0FF;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("redir_valid", 64'(inst_valid), 64'(k == 3));
      if (k == 3) chk("redir_addr", 64'(inst_addr), 64'(12'h0FF));
      cyc();
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 5; c++) cyc();

    // Address wrap
    redirect_valid = 1'b1;
    redirect_addr  = 12'hFFE;
    cyc();
    redirect_valid = 1'b0;
    got_q.delete();
    for (int c = 0; c < 8; c++) cyc();
    chk("wrap_count", 64'(got_q.size() >= 4), 64'(1'b1));
    if (got_q.size() >= 4) begin
      chk("wrap_0", 64'(got_q[0]), 64'(12'hFFE));
      chk("wrap_1", 64'(got_q[1]), 64'(12'hFFF));
      chk("wrap_2", 64'(got_q[2]), 64'(12'h000));
      chk("wrap_3", 64'(got_q[3]), 64'(12'h001));
    end

    // Halt under backpressure, drain, resume
    inst_ready = 1'b0;
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    a = imem_addr;
    for (int c = 0; c < 5; c++) begin
      chk("halt_busy", 64'(busy), 64'(1'b1));
      chk("halt_no_issue", 64'(imem_addr), 64'(a));
      cyc();
    end
    inst_ready = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      cyc();
      n++;
    end
    chk("halt_drain", 64'(busy), 64'(1'b0));
    chk("halt_pc", 64'(imem_addr), 64'(exp_addr));
    sz = got_q.size();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    chk("resume_progress", 64'(got_q.size() > sz), 64'(1'b1));

    // Redirect together with halt
    redirect_valid = 1'b1;
    halt = 1'b1;
    redirect_addr = 12'h123;
    cyc();
    redirect_valid = 1'b0;
    halt = 1'b0;
    chk("rh_busy", 64'(busy), 64'(1'b0));
    chk("rh_valid", 64'(inst_valid), 64'(1'b0));
    chk("rh_pc", 64'(imem_addr), 64'(12'h123));
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rh_idle", 64'(inst_valid), 64'(1'b0));
    end
    got_q.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    chk("rh_resume", 64'(got_q.size() > 0), 64'(1'b1));
    if (got_q.size() > 0) chk("rh_first", 64'(got_q[0]), 64'(12'h123));

    // Reset mid-stream
    inst_ready = 1'b0;
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk_reset("midrst");

    // Randomized traffic
    inst_ready = 1'b1;
    start = 1'b1;
    cyc();
    npops = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready     = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 59) == 0;
      redirect_addr  = 12'($urandom);
      halt           = $urandom_range(0, 99) == 0;
      start          = $urandom_range(0, 14) == 0;
      cyc();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    start = 1'b0;
    chk("rand_progress", 64'(npops > 300), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
